ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the attached keyboard. It complements the existing PS/2 keyboard receiver, shares the same `clk` domain (clkdiv[1], 25 MHz) and drives the PS/2 lines open-drain via output-enable signals. The top level ties `PS2_CLK = ps2_clk_oe ? 0 : 'bz`, and likewise for `PS2_DATA`. It also holds the receiver's `rdn` and uses `busy` to ignore received bytes during a transmission.

## Interface
- `INHIBIT_CYCLES`, 2500: `clk` cycles the host holds PS/2 clock low before requesting to send (100 us at 25 MHz).
- `TIMEOUT_CYCLES`, 375000: maximum `clk` cycles to wait for any device action (15 ms at 25 MHz).
- `clk`  in  1  system clock.
- `clrn`  in  1  reset. Synchronous and active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin value (asynchronous).
- `ps2_data`  in  1  raw PS/2 data pin value (asynchronous).
- `din`  in  8  command byte. Sampled on the cycle `wr` is accepted.
- `wr`  in  1  send request. Accepted only in IDLE.
- `ps2_clk_oe`  out  1  1 = pull PS/2 clock low. 0 = release.
- `ps2_data_oe`  out  1  1 = pull PS/2 data low. 0 = release.
- `busy`  out  1  high from the cycle after acceptance until return to IDLE.
- `done`  out  1  one-cycle pulse when a transfer ends, whether it succeeds or fails.
- `nack`  out  1  valid with `done`: the device did not pull data low in the ack slot.
- `timeout`  out  1  valid with `done`: a wait exceeded `TIMEOUT_CYCLES`.

## Operation
- Inputs pass through a 2-FF synchronizer plus a third register. A falling edge of PS/2 clock (`fall`) is sync2==0 && sync3==1.
- Parity is odd: parity = ~^din. The shift register holds {1(stop), parity, din[7:0]} and shifts out LSB first.
- Data line rule: `ps2_data_oe = ~current_bit`. A 1 bit means the line is released.
- FSM states:
  - IDLE: both oe = 0, busy = 0. When `wr` = 1, latch `din` and go to INHIBIT.
  - INHIBIT: `ps2_clk_oe` = 1, `ps2_data_oe` = 0. After INHIBIT_CYCLES cycles, go to REQ.
  - REQ: one cycle with both oe = 1 (start bit 0 while clock is still held), then go to SHIFT.
  - SHIFT: `ps2_clk_oe` = 0. Data line holds the start bit (low). On each `fall`, present the next bit: d0..d7, parity, then stop (released).
    - Bit counter runs 0..9.
    - On the `fall` that presents the stop bit, go to ACK.
  - ACK: data released. On the next `fall`, sample sync2 of data. A value of 1 sets the nack flag. Then go to RELEASE.
  - RELEASE: wait until synchronized clock and data are both 1, then go to FIN.
  - FIN: one cycle. `done` = 1, `nack`/`timeout` show the flags, then go to IDLE. Flags clear on entry to INHIBIT.
- Timeout counter:
  - Cleared on entry to SHIFT, ACK and RELEASE, and on every `fall`.
  - If it reaches TIMEOUT_CYCLES in SHIFT, ACK or RELEASE: set the timeout flag, release both lines immediately, go to FIN.
- `wr` while busy is ignored (no queueing). `wr` held high in FIN is not accepted until IDLE, on the following cycle.
- A `fall` during INHIBIT or REQ is ignored.
- Counter widths are $clog2 of the parameter plus 1. No wrap-around occurs before the terminal compare.

## Timing
- Reset: on a `clk` edge with `clrn` = 0, state goes to IDLE and every output is 0 (both lines released, busy = done = nack = timeout = 0). This holds mid-transfer: the lines are released on that same edge and no `done` is issued.
- `wr` accepted at edge t: busy = 1 and `ps2_clk_oe` = 1 from t+1. REQ occupies cycle t+1+INHIBIT_CYCLES. Clock is released at t+2+INHIBIT_CYCLES.
- Pin fall to `ps2_data_oe` update: 3 `clk` cycles (2 sync + edge detect, registered output). This is far inside the device's ≥15 us clock-low half period.
- `done` fires exactly one cycle after RELEASE sees both lines high. busy drops on the same edge that `done` drops.

## Test plan
- Test parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=300. The device model clocks with a 10-cycle half period and samples data on rising edges.
- Send 0xED with device ack → sampled frame is 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. Clock held low for exactly 20 cycles. One `done` pulse with nack=0, timeout=0.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0. Send 0x00 → parity 1. `done` with nack=0 in both cases.
- Device leaves data high in the ack slot → `done` with nack=1, timeout=0.
- Device never clocks after clock release → 300 cycles later, `done` with timeout=1. Both oe = 0 on that cycle.
- Device stops clocking after bit 4 → timeout. Then `wr` of 0xFF on the next IDLE cycle completes normally.
- Assert `clrn`=0 mid-SHIFT → both oe = 0 and busy = 0 on the next edge, no `done`. Pulse `wr` during busy → ignored: exactly one frame is sent.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the attached keyboard
// by driving the open-drain clock/data lines through output-enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] din,
    input  logic       wr,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StRelease,
        StFin
    } state_e;

    state_e        state;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic          fall;
    logic          tmo_hit;

    // clk_sync[1]/data_sync[1] are the synchronized values; clk_sync[2] is the edge-detect stage
    assign fall    = ~clk_sync[1] & clk_sync[2];
    assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state       <= StIdle;
            shreg       <= '0;
            bitcnt      <= '0;
            icnt        <= '0;
            tcnt        <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            nack        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (wr) begin
                        shreg       <= {1'b1, ~^din, din};
                        icnt        <= '0;
                        nack        <= 1'b0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_oe <= 1'b1;
                        state       <= StReq;
                    end else begin
                        icnt <= icnt + 1'b1;
                    end
                end
                StReq: begin
                    ps2_clk_oe <= 1'b0;
                    tcnt       <= '0;
                    bitcnt     <= '0;
                    state      <= StShift;
                end
                StShift: begin
                    if (fall) begin
                        tcnt        <= '0;
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= {1'b0, shreg[9:1]};
                        if (bitcnt == 4'd9) begin
                            state <= StAck;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        timeout     <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        state       <= StFin;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                StAck: begin
                    if (fall) begin
                        tcnt  <= '0;
                        nack  <= data_sync[1];
                        state <= StRelease;
                    end else if (tmo_hit) begin
                        timeout     <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        state       <= StFin;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                StRelease: begin
                    if (clk_sync[1] && data_sync[1]) begin
                        done  <= 1'b1;
                        state <= StFin;
                    end else if (fall) begin
                        tcnt <= '0;
                    end else if (tmo_hit) begin
                        timeout     <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        state       <= StFin;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                StFin: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard model and a
// scoreboard of expected transfer outcomes checked on every done pulse.
module tb_ps2_host_tx;

    localparam int MACK    = 0;
    localparam int MNOACK  = 1;
    localparam int MSILENT = 2;
    localparam int MSTALL  = 3;

    typedef struct {
        logic [10:0] frame;
        logic        nack;
        logic        tmo;
        logic        chk_frame;
    } exp_t;

    logic        clk;
    logic        clrn;
    logic [7:0]  din;
    logic        wr;
    logic        ps2_clk_oe;
    logic        ps2_data_oe;
    logic        busy;
    logic        done;
    logic        nack;
    logic        timeout;
    logic        dev_clk_low;
    logic        dev_data_low;
    logic        ps2_clk_bus;
    logic        ps2_data_bus;
    logic [10:0] dev_frame;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   done_cnt;

    assign ps2_clk_bus  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_bus = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(300)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk_bus),
        .ps2_data   (ps2_data_bus),
        .din        (din),
        .wr         (wr),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .nack       (nack),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every done pulse retires the oldest expected outcome.
    always @(negedge clk) begin
        exp_t e;
        if (clrn === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("nack", {31'd0, nack}, {31'd0, e.nack});
                check("timeout", {31'd0, timeout}, {31'd0, e.tmo});
                check("oe_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                if (e.chk_frame) check("frame", {21'd0, dev_frame}, {21'd0, e.frame});
            end
        end
    end

    // Device clock pulse: 10 cycles low, release, sample data on the rising edge.
    task automatic dev_pulse(output logic b);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b0;
        @(negedge clk);
        b = ps2_data_bus;
    endtask

    // Called and returns on a negedge; returns on the first IDLE cycle after done.
    task automatic send(input logic [7:0] d, input int mode, input bit poke);
        exp_t e;
        int   n;
        int   k;
        int   np;
        logic b;
        e.frame     = {1'b1, ~^d, d, 1'b0};
        e.nack      = (mode == MNOACK);
        e.tmo       = (mode == MSILENT || mode == MSTALL);
        e.chk_frame = (mode == MACK || mode == MNOACK);
        din = d;
        wr  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 wr = 1'b0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ps2_clk_oe && !ps2_data_oe) n++;
            else break;
        end
        check("inhibit_len", n, 20);
        check("req_phase", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd3);
        @(negedge clk);
        check("clk_release", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
        dev_frame    = '0;
        dev_frame[0] = ps2_data_bus;
        if (mode != MSILENT) begin
            repeat (10) @(negedge clk);
            np = (mode == MSTALL) ? 5 : 10;
            for (int i = 0; i < np; i++) begin
                if (poke && i == 3) begin
                    wr  = 1'b1;
                    din = 8'hAA;
                    @(negedge clk);
                    wr  = 1'b0;
                end
                dev_pulse(b);
                dev_frame[i+1] = b;
                if (i < np - 1) repeat (9) @(negedge clk);
            end
            if (mode == MACK || mode == MNOACK) begin
                repeat (9) @(negedge clk);
                dev_data_low = (mode == MACK);
                repeat (3) @(negedge clk);
                dev_pulse(b);
                dev_data_low = 1'b0;
            end
        end
        k = 0;
        while (!done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        if (mode == MSILENT) check("timeout_latency", k, 300);
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int dc;
        n_vec        = 0;
        n_err        = 0;
        done_cnt     = 0;
        clrn         = 1'b0;
        wr           = 1'b0;
        din          = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {26'd0, ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout}, 32'd0);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hED, MACK, 1'b0);
        dc = done_cnt;
        send(8'hF4, MACK, 1'b1);
        repeat (40) @(negedge clk);
        check("no_second_frame", {30'd0, ps2_clk_oe, busy}, 32'd0);
        check("frames_sent", done_cnt - dc, 1);
        send(8'h00, MACK, 1'b0);
        send(8'hA5, MNOACK, 1'b0);
        send(8'h3C, MSILENT, 1'b0);
        send(8'h12, MSTALL, 1'b0);
        send(8'hFF, MACK, 1'b0);

        // Abort a transfer mid-SHIFT with reset.
        dc  = done_cnt;
        din = 8'h55;
        wr  = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe) break;
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic b;
            dev_pulse(b);
            repeat (9) @(negedge clk);
        end
        clrn = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_shift", {28'd0, ps2_clk_oe, ps2_data_oe, busy, done}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (50) @(negedge clk);
        check("no_done_after_reset", done_cnt, dc);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
